ex_muldiv_iter: RTL

//  Iterative multi-cycle multiply/divide unit alongside the EX stage ALU. Executes

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/md_sign_fix.sv | 16 +
 rtl/ex_muldiv_iter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e      : operation encodings as presented on op_i
//   md_state_e   : control FSM states
//   MD_DIVZ_QUOT : quotient returned on divide-by-zero (all ones, sliced to WIDTH)
//   md_is_div    : op decodes to a divide
//   md_is_signed : op decodes to a signed operation
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_e;

    localparam logic [63:0] MD_DIVZ_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Takes magnitudes of signed operands on
// the way in and restores result signs on the way out.
//   val_i : value to fix up
//   neg_i : negate when high, pass through when low
//   val_o : fixed value
module md_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit beside the EX-stage ALU. One bit per cycle:
// shift-add for MULT/MULTU, restoring division for DIV/DIVU, on unsigned
// magnitudes with a sign fix-up on the final iteration.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : request, sampled only while idle
//   op_i           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa_i, opb_i   : multiplicand/dividend, multiplier/divisor
//   annul_i        : pipeline flush, drops an in-flight op
//   stallreq_o     : hold IF..EX while the unit is working
//   busy_o         : unit not idle
//   done_o         : one-cycle result strobe
//   hi_o, lo_o     : MUL product high/low, or DIV remainder/quotient
module ex_muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             stallreq_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // MUL: {0, partial product upper, multiplier/low product}
    // DIV: {partial remainder (W+1), dividend shifting out / quotient shifting in}
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_upper;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH:0]   step_next;
    logic [2*WIDTH-1:0] res_raw, res_fixed;
    logic [WIDTH-1:0]   rem_fixed, fin_hi, fin_lo;

    assign accept = (state_q == MD_IDLE) & start_i & ~annul_i;
    assign a_neg  = md_is_signed(op_i) & opa_i[WIDTH-1];
    assign b_neg  = md_is_signed(op_i) & opb_i[WIDTH-1];

    md_sign_fix #(.W(WIDTH)) u_fix_a (
        .val_i (opa_i),
        .neg_i (a_neg),
        .val_o (a_mag)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_b (
        .val_i (opb_i),
        .neg_i (b_neg),
        .val_o (b_mag)
    );

    // One iteration of either algorithm, from the current datapath register.
    always_comb begin
        mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // Remainder stays below the divisor, so bit W of the difference is a clean borrow.
        div_ok    = ~div_diff[WIDTH];
        if (is_div_q) begin
            step_next = {(div_ok ? div_diff : div_shift), acc_q[WIDTH-2:0], div_ok};
        end else begin
            step_next = {1'b0, mul_upper, acc_q[WIDTH-1:1]};
        end
    end

    // Final-iteration sign fix-up: the 2W negate serves the product and the quotient.
    assign res_raw = is_div_q ? {{WIDTH{1'b0}}, step_next[WIDTH-1:0]}
                              : step_next[2*WIDTH-1:0];

    md_sign_fix #(.W(2 * WIDTH)) u_fix_res (
        .val_i (res_raw),
        .neg_i (neg_res_q),
        .val_o (res_fixed)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val_i (step_next[2*WIDTH-1:WIDTH]),
        .neg_i (neg_rem_q),
        .val_o (rem_fixed)
    );

    assign fin_hi = is_div_q ? rem_fixed : res_fixed[2*WIDTH-1:WIDTH];
    assign fin_lo = res_fixed[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    is_div_d  = md_is_div(op_i);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_d       = b_mag;
                    cnt_d     = '0;
                    if (md_is_div(op_i) && (opb_i == '0)) begin
                        state_d = MD_DONE;
                        hi_d    = opa_i;
                        lo_d    = MD_DIVZ_QUOT[WIDTH-1:0];
                    end else begin
                        state_d = MD_RUN;
                        acc_d   = {{(WIDTH + 1){1'b0}}, a_mag};
                    end
                end
            end
            MD_RUN: begin
                if (annul_i) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = MD_DONE;
                        hi_d    = fin_hi;
                        lo_d    = fin_lo;
                    end
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Combinational from start_i so the issuing instruction holds in EX on its first cycle.
    assign stallreq_o = accept | (state_q == MD_RUN);
    assign busy_o     = (state_q != MD_IDLE);
    assign done_o     = (state_q == MD_DONE) & ~annul_i;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
